// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared state encoding, op codes and sizing helper for the I/O port controller
package io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IN  = 2'd1,
        HOLD_OUT = 2'd2,
        DONE     = 2'd3
    } io_state_t;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_IN   = 2'd1;
    localparam logic [1:0] OP_OUT  = 2'd2;

    // Counter width for a terminal count of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_debouncer.sv
// rtl/io_debouncer.sv - pushbutton synchroniser, stability filter and rising-edge detector
module io_debouncer
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    // The level only follows sync2 after it has disagreed for a full window;
    // any agreement in between throws the partial count away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
            key_level  <= 1'b0;
            key_rise   <= 1'b0;
        end else begin
            sync1    <= key_raw;
            sync2    <= sync1;
            key_rise <= 1'b0;
            if (sync2 != key_level) begin
                if (stable_cnt == CNT_LAST) begin
                    stable_cnt <= '0;
                    key_level  <= sync2;
                    key_rise   <= sync2;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - services CPU IN/OUT instructions against switches, Enter key and display
module io_port_controller
    import io_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            io_op,
    input  logic                  io_start,
    input  logic [DATA_WIDTH-1:0] switches,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic                  enter_key,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  io_busy,
    output logic                  io_done,
    output logic [DATA_WIDTH-1:0] binary,
    output logic                  in_on,
    output logic                  out_on
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    io_state_t     state;
    logic [HW-1:0] hold_cnt;
    logic          key_level;
    logic          key_rise;
    logic          press;

    io_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock    (clock),
        .reset    (reset),
        .key_raw  (enter_key),
        .key_level(key_level),
        .key_rise (key_rise)
    );

    assign press = key_rise & key_level;

    // Display keeps its last value in IDLE and DONE so the user can still read it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            in_data  <= '0;
            binary   <= '0;
            io_busy  <= 1'b0;
            io_done  <= 1'b0;
            in_on    <= 1'b0;
            out_on   <= 1'b0;
        end else begin
            io_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_start && io_op != OP_NONE) begin
                        case (io_op)
                            OP_IN: begin
                                state   <= WAIT_IN;
                                io_busy <= 1'b1;
                                in_on   <= 1'b1;
                            end
                            OP_OUT: begin
                                state    <= HOLD_OUT;
                                binary   <= reg_data;
                                hold_cnt <= '0;
                                io_busy  <= 1'b1;
                                out_on   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_IN: begin
                    binary <= switches;
                    if (press) begin
                        in_data <= switches;
                        state   <= DONE;
                        io_done <= 1'b1;
                        in_on   <= 1'b0;
                    end
                end
                HOLD_OUT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= DONE;
                        io_done  <= 1'b1;
                        out_on   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    io_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    io_busy <= 1'b0;
                    in_on   <= 1'b0;
                    out_on  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - directed and randomized checks of io_port_controller against a latency model
module tb_io_port_controller;

    localparam int DW   = 32;
    localparam int HOLD = 4;
    localparam int DEB  = 3;
    localparam int OUT_LAT = HOLD + 1;
    localparam int IN_LAT  = 2 + DEB + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    io_op;
    logic          io_start;
    logic [DW-1:0] switches;
    logic [DW-1:0] reg_data;
    logic          enter_key;
    logic [DW-1:0] in_data;
    logic          io_busy;
    logic          io_done;
    logic [DW-1:0] binary;
    logic          in_on;
    logic          out_on;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_binary;
    logic [DW-1:0] exp_in_data;

    io_port_controller #(
        .DATA_WIDTH     (DW),
        .HOLD_CYCLES    (HOLD),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .io_op    (io_op),
        .io_start (io_start),
        .switches (switches),
        .reg_data (reg_data),
        .enter_key(enter_key),
        .in_data  (in_data),
        .io_busy  (io_busy),
        .io_done  (io_done),
        .binary   (binary),
        .in_on    (in_on),
        .out_on   (out_on)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (io_done !== 1'b1 && n < 200);
    endtask

    task automatic start_op(input logic [1:0] op, input logic [DW-1:0] rd);
        io_op    = op;
        reg_data = rd;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
    endtask

    task automatic no_done(input int cycles, input string tag);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (io_done === 1'b1) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, io_busy, 1'b0);
        check({tag, "_done"}, io_done, 1'b0);
        check({tag, "_binary"}, binary, exp_binary);
        check({tag, "_in_data"}, in_data, exp_in_data);
    endtask

    initial begin
        int n;
        logic [1:0]    op;
        logic [DW-1:0] rd;
        logic [DW-1:0] sw;

        reset = 1'b1; io_op = 2'd0; io_start = 1'b0;
        switches = '0; reg_data = '0; enter_key = 1'b0;
        exp_binary = '0; exp_in_data = '0;
        tick(); tick();
        check("rst_in_data", in_data, 0);
        check("rst_binary", binary, 0);
        check("rst_busy", io_busy, 0);
        check("rst_done", io_done, 0);
        check("rst_in_on", in_on, 0);
        check("rst_out_on", out_on, 0);
        #2 reset = 1'b0;
        tick();

        // OUT: held for HOLD cycles, display persists afterwards
        start_op(2'd2, 32'hDEADBEEF);
        check("out_busy", io_busy, 1);
        check("out_on", out_on, 1);
        check("out_in_on", in_on, 0);
        check("out_binary", binary, 32'hDEADBEEF);
        wait_done(n);
        check("out_latency", n + 1, OUT_LAT);
        check("out_done_busy", io_busy, 1);
        check("out_done_out_on", out_on, 0);
        exp_binary = 32'hDEADBEEF;
        tick();
        check_idle_outputs("out_after");

        // IN: live echo, clean press
        start_op(2'd1, '0);
        check("in_on", in_on, 1);
        check("in_out_on", out_on, 0);
        check("in_busy", io_busy, 1);
        switches = 32'h5; tick();
        check("in_echo5", binary, 32'h5);
        switches = 32'hA; tick();
        check("in_echoA", binary, 32'hA);
        enter_key = 1'b1;
        wait_done(n);
        check("in_latency", n, IN_LAT);
        check("in_data_A", in_data, 32'hA);
        check("in_on_drop", in_on, 0);
        exp_in_data = 32'hA; exp_binary = 32'hA;
        tick();
        enter_key = 1'b0;
        check_idle_outputs("in_after");
        repeat (8) tick();

        // Bounce 1,0,1 then hold: one event counted from the last rise
        start_op(2'd1, '0);
        switches = 32'h1234;
        enter_key = 1'b1; tick();
        enter_key = 1'b0; tick();
        enter_key = 1'b1;
        wait_done(n);
        check("bounce_latency", n + 2, 2 + IN_LAT);
        check("bounce_in_data", in_data, 32'h1234);
        exp_in_data = 32'h1234; exp_binary = 32'h1234;
        no_done(15, "bounce_single_done");

        // Key already held when WAIT_IN is entered
        start_op(2'd1, '0);
        switches = 32'h77;
        no_done(15, "held_no_done");
        check("held_busy", io_busy, 1);
        enter_key = 1'b0;
        repeat (DEB + 4) tick();
        check("held_release_busy", io_busy, 1);
        enter_key = 1'b1;
        wait_done(n);
        check("held_repress_latency", n, IN_LAT);
        check("held_in_data", in_data, 32'h77);
        exp_in_data = 32'h77; exp_binary = 32'h77;
        tick();
        enter_key = 1'b0;
        repeat (8) tick();

        // Ignored requests
        start_op(2'd0, 32'h1);
        check("op0_busy", io_busy, 0);
        no_done(5, "op0_no_done");
        start_op(2'd3, 32'h2);
        check("op3_busy", io_busy, 0);
        no_done(5, "op3_no_done");
        check_idle_outputs("ignored");
        start_op(2'd2, 32'h11111111);
        io_op = 2'd2; reg_data = 32'h22222222; io_start = 1'b1;
        tick();
        io_start = 1'b0;
        check("restart_binary", binary, 32'h11111111);
        wait_done(n);
        check("restart_latency", n + 2, OUT_LAT);
        check("restart_binary_done", binary, 32'h11111111);
        exp_binary = 32'h11111111;
        no_done(10, "restart_single_done");

        // Asynchronous reset in the middle of HOLD_OUT
        start_op(2'd2, 32'hCAFEF00D);
        tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_in_data", in_data, 0);
        check("mid_rst_binary", binary, 0);
        check("mid_rst_busy", io_busy, 0);
        check("mid_rst_done", io_done, 0);
        check("mid_rst_in_on", in_on, 0);
        check("mid_rst_out_on", out_on, 0);
        #3 reset = 1'b0;
        exp_binary = '0; exp_in_data = '0;
        no_done(10, "mid_rst_no_done");
        check_idle_outputs("mid_rst_after");

        // Back-to-back OUT then IN on the cycle after io_done
        start_op(2'd2, 32'hA5A5A5A5);
        wait_done(n);
        check("b2b_out_latency", n + 1, OUT_LAT);
        tick();
        start_op(2'd1, '0);
        check("b2b_in_busy", io_busy, 1);
        check("b2b_in_on", in_on, 1);
        switches = 32'h42;
        enter_key = 1'b1;
        wait_done(n);
        check("b2b_in_latency", n, IN_LAT);
        check("b2b_in_data", in_data, 32'h42);
        tick();
        check("b2b_done_pulse", io_done, 0);
        exp_in_data = 32'h42; exp_binary = 32'h42;
        enter_key = 1'b0;
        repeat (8) tick();

        // Randomized operations against the latency / value model
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            rd = $urandom;
            sw = $urandom;
            switches = sw;
            start_op(op, rd);
            if (op == 2'd2) begin
                check("rnd_out_binary", binary, rd);
                wait_done(n);
                check("rnd_out_latency", n + 1, OUT_LAT);
                exp_binary = rd;
                tick();
            end else if (op == 2'd1) begin
                repeat ($urandom_range(0, 3)) tick();
                enter_key = 1'b1;
                wait_done(n);
                check("rnd_in_latency", n, IN_LAT);
                exp_in_data = sw; exp_binary = sw;
                tick();
                enter_key = 1'b0;
                repeat (8) tick();
            end else begin
                check("rnd_nop_busy", io_busy, 0);
            end
            check_idle_outputs("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
